cpu_param_seq: RTL and testbench



---
 rtl/cpu_param_seq.sv | 177 +++++++++++++++++
 tb/tb_cpu_param_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_param_seq.sv
// cpu_param_seq: parametrised IDLE/EXEC/WB instruction sequencer with flop register file and data memory.
// Build option CPU_SAT_ADD_EN: ADD clamps to the signed limits on overflow instead of wrapping.
module cpu_param_seq #(
   parameter int DATA_W    = 4,
   parameter int NUM_REGS  = 4,
   parameter int MEM_DEPTH = 16,
   localparam int RA_W     = $clog2(NUM_REGS),
   localparam int MA_W     = $clog2(MEM_DEPTH),
   localparam int F_W      = (2*RA_W >= MA_W) ? ((2*RA_W >= DATA_W) ? 2*RA_W : DATA_W)
                                              : ((MA_W >= DATA_W) ? MA_W : DATA_W),
   localparam int INSTR_W  = 3 + F_W + RA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic               done,
   output logic               overflow,
   input  logic [RA_W-1:0]    dbg_reg_sel,
   output logic [DATA_W-1:0]  dbg_reg_data,
   input  logic [MA_W-1:0]    dbg_mem_sel,
   output logic [DATA_W-1:0]  dbg_mem_data
);

   // Handshake: an instruction transfers on the rising edge where instr_valid && instr_ready;
   // instr_ready is high only in IDLE, and instr/instr_valid are ignored otherwise.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_ST  = 3'b101;
   localparam logic [2:0] OP_LD  = 3'b110;
   localparam logic [2:0] OP_LI  = 3'b111;

   localparam logic [MA_W:0] MEM_LIMIT = (MA_W+1)'(MEM_DEPTH);

`ifdef CPU_SAT_ADD_EN
   localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};
`endif

   state_t              r_state;
   state_t              w_next_state;
   logic [INSTR_W-1:0]  r_instr;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [DATA_W-1:0]   r_mem  [MEM_DEPTH];
   logic [DATA_W-1:0]   r_result;
   logic                r_ovf_cand;
   logic                r_overflow;
   logic                r_done;

   logic                w_accept;
   logic                w_exec;
   logic                w_commit;

   logic [2:0]          w_op;
   logic [F_W-1:0]      w_f;
   logic [RA_W-1:0]     w_rd;
   logic [RA_W-1:0]     w_rs;
   logic [RA_W-1:0]     w_rt;
   logic [MA_W-1:0]     w_addr;
   logic                w_addr_ok;
   logic [DATA_W-1:0]   w_a;
   logic [DATA_W-1:0]   w_b;
   logic [DATA_W-1:0]   w_rd_val;
   logic [DATA_W-1:0]   w_mem_rd;
   logic [DATA_W-1:0]   w_sum;
   logic                w_add_ovf;
   logic [DATA_W-1:0]   w_result;

   // Decode always works from the latched word, so instr may change while busy.
   assign w_op      = r_instr[INSTR_W-1 -: 3];
   assign w_f       = r_instr[RA_W +: F_W];
   assign w_rd      = r_instr[RA_W-1:0];
   assign w_rs      = w_f[F_W-1 -: RA_W];
   assign w_rt      = w_f[F_W-RA_W-1 -: RA_W];
   assign w_addr    = w_f[MA_W-1:0];
   assign w_addr_ok = ({1'b0, w_addr} < MEM_LIMIT);
   assign w_a       = r_regs[w_rs];
   assign w_b       = r_regs[w_rt];
   assign w_rd_val  = r_regs[w_rd];
   assign w_mem_rd  = w_addr_ok ? r_mem[w_addr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (instr_valid) w_next_state = S_EXEC;
         S_EXEC:  w_next_state = S_WB;
         S_WB:    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (r_state == S_IDLE);
      w_accept    = (r_state == S_IDLE) && instr_valid;
      w_exec      = (r_state == S_EXEC);
      w_commit    = (r_state == S_WB);
   end

   always_comb begin
      w_sum     = w_a + w_b;
      w_add_ovf = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);
      w_result  = '0;
      case (w_op)
         OP_ADD: begin
            w_result = w_sum;
`ifdef CPU_SAT_ADD_EN
            if (w_add_ovf) w_result = w_a[DATA_W-1] ? SAT_NEG : SAT_POS;
`endif
         end
         OP_AND:  w_result = w_a & w_b;
         OP_OR:   w_result = w_a | w_b;
         OP_NOT:  w_result = ~w_a;
         OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
         OP_ST:   w_result = w_rd_val;
         OP_LD:   w_result = w_mem_rd;
         OP_LI:   w_result = w_f[DATA_W-1:0];
         default: w_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_instr <= '0;
      else if (w_accept) r_instr <= instr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result   <= '0;
         r_ovf_cand <= 1'b0;
      end else if (w_exec) begin
         r_result   <= w_result;
         r_ovf_cand <= w_add_ovf;
      end
   end

   // Architectural state only changes on the WB edge; a reset before it drops the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)  r_regs[i] <= '0;
         for (int j = 0; j < MEM_DEPTH; j++) r_mem[j]  <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_commit) begin
            if (w_op == OP_ST) begin
               if (w_addr_ok) r_mem[w_addr] <= r_result;
            end else begin
               r_regs[w_rd] <= r_result;
            end
            if (w_op == OP_ADD) r_overflow <= r_ovf_cand;
         end
      end
   end

   assign done         = r_done;
   assign overflow     = r_overflow;
   assign dbg_reg_data = r_regs[dbg_reg_sel];
   assign dbg_mem_data = ({1'b0, dbg_mem_sel} < MEM_LIMIT) ? r_mem[dbg_mem_sel] : '0;

endmodule

// File: tb/tb_cpu_param_seq.sv
// Self-checking bench for cpu_param_seq (default parameters): reference model feeds an expected queue
// popped on every done pulse; honours CPU_SAT_ADD_EN for the ADD result.
module tb_cpu_param_seq;

   localparam int DATA_W    = 4;
   localparam int NUM_REGS  = 4;
   localparam int MEM_DEPTH = 16;

`ifdef CPU_SAT_ADD_EN
   localparam logic [3:0] EXP_ADD_POS = 4'h7;
   localparam logic [3:0] EXP_ADD_NEG = 4'h8;
`else
   localparam logic [3:0] EXP_ADD_POS = 4'h8;
   localparam logic [3:0] EXP_ADD_NEG = 4'h1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic       done;
   logic       overflow;
   logic [1:0] dbg_reg_sel;
   logic [3:0] dbg_reg_data;
   logic [3:0] dbg_mem_sel;
   logic [3:0] dbg_mem_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] m_regs [4];
   logic [3:0] m_mem  [16];
   logic       m_ovf;

   logic [3:0] exp_q  [$];
   logic [3:0] sel_q  [$];
   logic       kind_q [$];
   logic       ovf_q  [$];

   always #5 clk = ~clk;

   cpu_param_seq #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .done         (done),
      .overflow     (overflow),
      .dbg_reg_sel  (dbg_reg_sel),
      .dbg_reg_data (dbg_reg_data),
      .dbg_mem_sel  (dbg_mem_sel),
      .dbg_mem_data (dbg_mem_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++)  m_regs[i] = '0;
      for (int j = 0; j < 16; j++) m_mem[j]  = '0;
      m_ovf = 1'b0;
   endtask

   task automatic model_exec(input logic [8:0] i);
      logic [2:0] op;
      logic [3:0] f, a, b, res;
      logic [1:0] rd;
      op  = i[8:6];
      f   = i[5:2];
      rd  = i[1:0];
      a   = m_regs[f[3:2]];
      b   = m_regs[f[1:0]];
      res = '0;
      case (op)
         3'b000: begin
            res = a + b;
            if ((a[3] == b[3]) && (res[3] != a[3])) begin
               m_ovf = 1'b1;
`ifdef CPU_SAT_ADD_EN
               res = a[3] ? 4'h8 : 4'h7;
`endif
            end else begin
               m_ovf = 1'b0;
            end
         end
         3'b001:  res = a & b;
         3'b010:  res = a | b;
         3'b011:  res = ~a;
         3'b100:  res = (a < b) ? 4'd1 : 4'd0;
         3'b101:  res = m_regs[rd];
         3'b110:  res = m_mem[f];
         default: res = f;
      endcase
      if (op == 3'b101) begin
         m_mem[f] = res;
         kind_q.push_back(1'b1);
         sel_q.push_back(f);
      end else begin
         m_regs[rd] = res;
         kind_q.push_back(1'b0);
         sel_q.push_back({2'b00, rd});
      end
      exp_q.push_back(res);
      ovf_q.push_back(m_ovf);
   endtask

   task automatic check_commit();
      logic [3:0] e, s;
      logic       k, eo;
      check("sb_entry_present", (exp_q.size() > 0), 1);
      if (exp_q.size() == 0) return;
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      k  = kind_q.pop_front();
      eo = ovf_q.pop_front();
      if (k) begin
         dbg_mem_sel = s;
         #1;
         check("mem_commit", dbg_mem_data, e);
      end else begin
         dbg_reg_sel = s[1:0];
         #1;
         check("reg_commit", dbg_reg_data, e);
      end
      check("overflow_commit", overflow, eo);
   endtask

   // Entered between edges; drives one instruction and follows it to its done pulse.
   task automatic send(input logic [8:0] i);
      int n;
      n = 0;
      while (!instr_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_send", instr_ready, 1);
      instr       = i;
      instr_valid = 1'b1;
      model_exec(i);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = 9'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 8);
      check("done_latency", n, 3);
      check("ready_with_done", instr_ready, 1);
      check_commit();
   endtask

   task automatic read_reg(input logic [1:0] r, output logic [3:0] v);
      @(negedge clk);
      dbg_reg_sel = r;
      #1;
      v = dbg_reg_data;
   endtask

   task automatic check_all(input string tag);
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         dbg_reg_sel = 2'(r);
         #1;
         check({tag, "_reg"}, dbg_reg_data, m_regs[r]);
      end
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         dbg_mem_sel = 4'(a);
         #1;
         check({tag, "_mem"}, dbg_mem_data, m_mem[a]);
      end
      check({tag, "_ovf"}, overflow, m_ovf);
   endtask

   // Accepts an ADD, then pulls reset during EXEC (in_wb=0) or WB (in_wb=1).
   task automatic reset_mid(input logic in_wb, input string tag);
      @(negedge clk);
      instr       = 9'b000_01_10_11;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      if (in_wb) @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      repeat (2) begin
         @(negedge clk);
         check({tag, "_done_in_reset"}, done, 0);
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check({tag, "_done_after"}, done, 0);
      end
      check({tag, "_ready"}, instr_ready, 1);
      check_all(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [3:0] v;
      int         ndone;
      rst_n       = 1'b0;
      instr       = '0;
      instr_valid = 1'b0;
      dbg_reg_sel = '0;
      dbg_mem_sel = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", instr_ready, 1);
      check("reset_done", done, 0);
      check("reset_ovf", overflow, 0);
      check_all("reset");

      // Positive overflow, then a clean ADD.
      send(9'b111_0101_01);
      send(9'b111_0011_10);
      send(9'b000_01_10_11);
      read_reg(2'd3, v);
      check("add_5_3", v, EXP_ADD_POS);
      check("add_5_3_ovf", overflow, 1);
      send(9'b111_0010_01);
      send(9'b000_01_10_11);
      read_reg(2'd3, v);
      check("add_2_3", v, 4'd5);
      check("add_2_3_ovf", overflow, 0);

      // Store/load and logic ops.
      send(9'b101_1001_11);
      @(negedge clk);
      dbg_mem_sel = 4'd9;
      #1;
      check("st_mem9", dbg_mem_data, 4'd5);
      send(9'b110_1001_00);
      read_reg(2'd0, v);
      check("ld_r0", v, 4'd5);
      send(9'b111_0000_00);
      send(9'b001_01_10_00);
      read_reg(2'd0, v);
      check("and_2_3", v, 4'd2);
      send(9'b010_01_10_00);
      read_reg(2'd0, v);
      check("or_2_3", v, 4'd3);
      send(9'b011_01_00_00);
      read_reg(2'd0, v);
      check("not_2", v, 4'hD);

      // Unsigned set-less-than; overflow must hold at 0.
      send(9'b100_01_10_00);
      read_reg(2'd0, v);
      check("slt_2_3", v, 4'd1);
      send(9'b100_10_01_00);
      read_reg(2'd0, v);
      check("slt_3_2", v, 4'd0);
      send(9'b100_01_01_00);
      read_reg(2'd0, v);
      check("slt_2_2", v, 4'd0);
      check("slt_ovf_hold", overflow, 0);

      // Negative overflow: 8 + 9 as signed is -8 + -7.
      send(9'b111_1000_01);
      send(9'b111_1001_10);
      send(9'b000_01_10_11);
      read_reg(2'd3, v);
      check("add_neg", v, EXP_ADD_NEG);
      check("add_neg_ovf", overflow, 1);

      // Random instructions against the model.
      for (int k = 0; k < 24; k++) send(9'($urandom_range(0, 511)));
      check_all("random");

      // Held valid with a changing LI stream: only every third word may execute.
      @(negedge clk);
      ndone = 0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         if (done) begin
            ndone++;
            check_commit();
         end
         check("stream_ready", instr_ready, (c % 3 == 0));
         instr       = {3'b111, 4'(c + 3), 2'(c)};
         instr_valid = 1'b1;
         if (c % 3 == 0) model_exec(instr);
      end
      @(negedge clk);
      instr_valid = 1'b0;
      if (done) begin
         ndone++;
         check_commit();
      end
      check("stream_done_count", ndone, 3);
      check_all("stream");

      // Reset in the middle of an ADD, first in EXEC then in WB.
      send(9'b111_0101_01);
      send(9'b111_0011_10);
      reset_mid(1'b0, "rst_exec");
      send(9'b111_0101_01);
      send(9'b111_0011_10);
      reset_mid(1'b1, "rst_wb");

      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
